// File: rtl/mcdt_param_pkg.sv
// Shared types and width helpers for the parametrised multi-channel data transfer block.
package mcdt_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    function automatic int unsigned calc_id_w(input int unsigned num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

    function automatic int unsigned calc_margin_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mcdt_param_if.sv
// Channel write ports and merged output stream of mcdt_param; slave modport is the block side.
interface mcdt_param_if
    import mcdt_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 32
);
    localparam int unsigned ID_W     = calc_id_w(NUM_CH);
    localparam int unsigned MARGIN_W = calc_margin_w(FIFO_DEPTH);

    logic [NUM_CH*DATA_W-1:0]   ch_data_i;
    logic [NUM_CH-1:0]          ch_valid_i;
    logic [NUM_CH-1:0]          ch_ready_o;
    logic [NUM_CH*MARGIN_W-1:0] ch_margin_o;
    logic [NUM_CH-1:0]          ch_en_i;
    logic [DATA_W-1:0]          mcdt_data_o;
    logic                       mcdt_val_o;
    logic [ID_W-1:0]            mcdt_id_o;

    modport master (
        output ch_data_i, ch_valid_i, ch_en_i,
        input  ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
    );

    modport slave (
        input  ch_data_i, ch_valid_i, ch_en_i,
        output ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
    );

endinterface

// File: rtl/mcdt_chnl_fifo.sv
// Per-channel FIFO with registered occupancy count; ready and margin come from the count
// register only, so a pop never frees a slot within the same cycle.
module mcdt_chnl_fifo
    import mcdt_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 32,
    localparam int unsigned CNT_W     = calc_margin_w(FIFO_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ready_o,
    output logic [CNT_W-1:0]  margin_o
);

    localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, rd_en;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_en   = push_i && (count_q != DEPTH_C);
        rd_en   = pop_i && (count_q != '0);
        wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd_en ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o   = mem_q[rptr_q];
    assign count_o  = count_q;
    assign ready_o  = (count_q != DEPTH_C);
    assign margin_o = DEPTH_C - count_q;

endmodule

// File: rtl/mcdt_param.sv
// Multi-channel data transfer: NUM_CH channel FIFOs merged onto one registered, id-tagged
// output stream by a fixed-priority or round-robin arbiter with per-channel enables.
module mcdt_param
    import mcdt_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned ARB_MODE   = 1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    mcdt_param_if.slave  bus
);

    localparam int unsigned ID_W     = calc_id_w(NUM_CH);
    localparam int unsigned MARGIN_W = calc_margin_w(FIFO_DEPTH);
    localparam arb_mode_e   MODE     = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [DATA_W-1:0]          fifo_dout [NUM_CH];
    logic [MARGIN_W-1:0]        fifo_count [NUM_CH];
    logic [NUM_CH-1:0]          ready_vec;
    logic [NUM_CH*MARGIN_W-1:0] margin_vec;
    logic [NUM_CH-1:0]          eligible;
    logic [NUM_CH-1:0]          pop;
    logic                       grant_vld;
    logic [ID_W-1:0]            grant_idx;

    logic                       val_q, val_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mcdt_chnl_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .push_i   (bus.ch_valid_i[k]),
            .data_i   (bus.ch_data_i[k*DATA_W +: DATA_W]),
            .pop_i    (pop[k]),
            .data_o   (fifo_dout[k]),
            .count_o  (fifo_count[k]),
            .ready_o  (ready_vec[k]),
            .margin_o (margin_vec[k*MARGIN_W +: MARGIN_W])
        );
    end

    // Round-robin scans ptr+1 .. ptr (wrapping), fixed priority scans 0 .. NUM_CH-1.
    always_comb begin
        int unsigned idx;
        eligible  = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            eligible[k] = (fifo_count[k] != '0) && bus.ch_en_i[k];
        end
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            if (MODE == ARB_RR) begin
                idx = 32'(ptr_q) + off;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
            end else begin
                idx = off - 1;
            end
            if (!grant_vld && eligible[ID_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
        val_d  = grant_vld;
        data_d = grant_vld ? fifo_dout[grant_idx] : '0;
        id_d   = grant_vld ? grant_idx : id_q;
        ptr_d  = ((MODE == ARB_RR) && grant_vld) ? grant_idx : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            val_q  <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= ID_W'(NUM_CH - 1);
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.ch_ready_o  = ready_vec;
    assign bus.ch_margin_o = margin_vec;
    assign bus.mcdt_val_o  = val_q;
    assign bus.mcdt_data_o = data_q;
    assign bus.mcdt_id_o   = id_q;

endmodule

// File: doc/mcdt_param.md
Name: mcdt_param

Overview:
Parametrised multi-channel data transfer block, successor to the fixed 3-channel mcdt. It provides NUM_CH slave channels, each with a valid/ready write port, a FIFO of FIFO_DEPTH words and a free-slot margin report. An arbiter merges the channels onto a single registered output stream tagged with the source channel id. Arbitration is fixed-priority or round-robin, selected by parameter, and each channel has a runtime enable.

Parameters:
NUM_CH, 3, number of input channels (2..16)
DATA_W, 32, data width per channel
FIFO_DEPTH, 32, words per channel FIFO (power of 2, >=2)
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
ID_W, derived: max(1,$clog2(NUM_CH)), not overridable
MARGIN_W, derived: $clog2(FIFO_DEPTH+1), not overridable

Ports:
clk_i  in  1  clock, single domain
rstn_i  in  1  asynchronous active-low reset
ch_data_i  in  NUM_CH*DATA_W  channel k data at [k*DATA_W +: DATA_W]
ch_valid_i  in  NUM_CH  per-channel write valid
ch_ready_o  out  NUM_CH  per-channel FIFO not full
ch_margin_o  out  NUM_CH*MARGIN_W  per-channel free slots, channel k at [k*MARGIN_W +: MARGIN_W]
ch_en_i  in  NUM_CH  per-channel arbitration enable
mcdt_data_o  out  DATA_W  merged output data
mcdt_val_o  out  1  output data valid, one-cycle pulse per word
mcdt_id_o  out  ID_W  source channel of mcdt_data_o

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, count=0. mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0. ch_ready_o all 1, ch_margin_o=FIFO_DEPTH per channel. RR pointer = NUM_CH-1, so channel 0 is granted first.
- Write: accepted on a clk_i edge when ch_valid_i[k] & ch_ready_o[k]. If valid is high while ready is low, the word is ignored and the sender must hold it. No backpressure on the output side.
- ch_ready_o[k] = (count_k != FIFO_DEPTH). Derived from the registered count only; a pop in the same cycle does not free a slot early.
- ch_margin_o[k] = FIFO_DEPTH - count_k, registered-count based.
- Simultaneous push and pop on one channel: count unchanged, both occur. Read and write pointers wrap modulo FIFO_DEPTH.
- Eligibility: channel k is eligible when FIFO k is not empty and ch_en_i[k]=1.
- Arbiter: combinational grant among eligible channels each cycle; at most one pop per cycle. The granted word is popped and registered into mcdt_data_o/mcdt_id_o with mcdt_val_o=1 at the next edge.
- When no channel is eligible: mcdt_val_o=0 and mcdt_data_o=0; mcdt_id_o holds its last value.
- Latency: word accepted at edge t into an empty FIFO, with no competition, gives mcdt_val_o=1 in the cycle after edge t+1. Sustained throughput is 1 word/cycle aggregate.
- ARB_MODE=0: lowest eligible index wins, so starvation is permitted.
- ARB_MODE=1: search starts at ptr+1 and wraps at NUM_CH-1 to 0. ptr updates to the granted index only on a grant.
- ch_en_i deasserted: the channel keeps accepting writes until full, but is never granted. Re-enabling resumes in FIFO order with no data loss.
- Reset mid-operation: FIFO contents and any in-flight output are discarded. Outputs return to reset values immediately on rstn_i low.
- Per-channel data order is preserved. Words are never duplicated or dropped once accepted.

Decomposition:
- Package mcdt_pkg holds:
  - localparam helpers for ID_W and MARGIN_W calculation
  - typedef enum {ARB_FIXED=0, ARB_RR=1} arb_mode_e
- Sub-module mcdt_chnl_fifo (DATA_W, FIFO_DEPTH): push/pop, data out, count, ready, margin. It is instantiated NUM_CH times via generate.
- Arbiter and output register stay in the top level, about 80 lines.

Test Plan:
1. Reset, then idle for 10 cycles -> ch_ready_o=3'b111, each margin=32, mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0.
2. Default params; write 100 words on ch0 (0x00C0_0000+i) with ch1/ch2 idle -> 100 output pulses, id=0, data in order, margin never below 31.
3. ch_en_i=3'b000; write 33 words back-to-back on ch1 -> after 32 accepts ready[1]=0 and margin=0. The 33rd word is held until ch_en_i[1]=1; then all 33 words exit in order.
4. ARB_MODE=1; preload 4 words in each of ch0..ch2, then enable all -> ids follow 0,1,2,0,1,2,... for 12 consecutive valid cycles.
5. ARB_MODE=0; same preload as scenario 4 -> ids 0,0,0,0,1,1,1,1,2,2,2,2.
6. Assert rstn_i low mid-stream while ch2 holds 5 words -> mcdt_val_o drops to 0 immediately. After release, margin[2]=32 and no stale word is emitted.
